// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Central reset controller for a single clock domain. On power-up (rst_i)
//   or on a reset request (rst_req_i), it holds every downstream reset low
//   for a minimum pulse width. It then releases the active-low reset lines
//   one stage at a time, bit 0 first, with a fixed gap between stages. It
//   sits after the async-assert/sync-deassert reset synchronizer and drives
//   the per-subsystem rstn lines.
//
// Optional feature:
//   `define RST_REQ_FILTER_EN to qualify rst_req_i. The request must then be
//   sampled high for FILTER_CYCLES consecutive cycles before it takes effect.
//   Without the macro, rst_req_i acts directly and FILTER_CYCLES is unused.
//
// Parameters:
//   NUM_STAGES    number of sequenced reset outputs (>=1)
//   MIN_PULSE     cycles all outputs are held in reset before release starts
//   STAGE_DLY     cycles between consecutive stage releases
//   FILTER_CYCLES request qualification length (filter build only)
//
// Ports:
//   clk_i        in   1           clock
//   rst_i        in   1           synchronous active-high reset
//   rst_req_i    in   1           level reset request (watchdog, software)
//   rstn_o       out  NUM_STAGES  active-low sequenced resets, bit 0 first
//   busy_o       out  1           high while any output is still in reset
//   done_o       out  1           one-cycle pulse when the last stage releases
//   rst_cause_o  out  2           00 = rst_i, 01 = rst_req_i
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int MIN_PULSE     = 16,
    parameter int STAGE_DLY     = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rst_req_i,
    output logic [NUM_STAGES-1:0] rstn_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            rst_cause_o
);

    localparam int MAX_AB  = (MIN_PULSE > STAGE_DLY) ? MIN_PULSE : STAGE_DLY;
    localparam int MAX_CNT = (MAX_AB > FILTER_CYCLES) ? MAX_AB : FILTER_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int STG_W   = $clog2(NUM_STAGES) + 1;

    // The edge that enters HOLD leaves cnt at 0, and the first quiet edge
    // after it is pulse cycle 0. HOLD therefore ends on the edge where cnt
    // reaches MIN_PULSE. That places stage k at edge
    // MIN_PULSE + (k+1)*STAGE_DLY, counted from the first quiet edge.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(STAGE_DLY - 1);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

    localparam logic [1:0] CAUSE_RST = 2'b00;
    localparam logic [1:0] CAUSE_REQ = 2'b01;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        RELEASE = 2'b01,
        RUN     = 2'b10
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [STG_W-1:0]      stage;
    logic [STG_W-1:0]      stage_next;
    logic [NUM_STAGES-1:0] rstn_next;
    logic                  busy_next;
    logic                  done_next;
    logic [1:0]            cause_next;
    logic                  req;

`ifdef RST_REQ_FILTER_EN
    // filt_cnt counts the consecutive high samples that came before the
    // current one. It saturates at FILTER_CYCLES-1. The request qualifies on
    // the FILTER_CYCLES-th consecutive high sample and then stays qualified
    // while the input stays high.
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] filt_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || !rst_req_i) begin
            filt_cnt <= '0;
        end else if (filt_cnt != FILT_LAST) begin
            filt_cnt <= filt_cnt + CNT_W'(1);
        end
    end

    assign req = rst_req_i && (filt_cnt == FILT_LAST);
`else
    assign req = rst_req_i;
`endif

    // State and output registers. Every output is registered, and rst_i
    // overrides any request on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= HOLD;
            cnt         <= '0;
            stage       <= '0;
            rstn_o      <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            rst_cause_o <= CAUSE_RST;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            stage       <= stage_next;
            rstn_o      <= rstn_next;
            busy_o      <= busy_next;
            done_o      <= done_next;
            rst_cause_o <= cause_next;
        end
    end

    // Next-state and next-output logic.
    // A request takes priority over normal sequencing in every state. A
    // request on the final release edge therefore aborts the release: the
    // last bit never rises and done never pulses.
    // A stage is released by shifting a 1 into the bottom of rstn. This
    // keeps the outputs thermometer coded by construction.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stage_next = stage;
        rstn_next  = rstn_o;
        done_next  = 1'b0;
        cause_next = rst_cause_o;

        if (req) begin
            state_next = HOLD;
            cnt_next   = '0;
            stage_next = '0;
            rstn_next  = '0;
            cause_next = CAUSE_REQ;
        end else begin
            case (state)
                HOLD: begin
                    rstn_next = '0;
                    if (cnt == HOLD_LAST) begin
                        state_next = RELEASE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    if (cnt == REL_LAST) begin
                        rstn_next  = (rstn_o << 1) | NUM_STAGES'(1);
                        cnt_next   = '0;
                        stage_next = stage + STG_W'(1);
                        if (stage == LAST_STAGE) begin
                            state_next = RUN;
                            done_next  = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end

                RUN: begin
                    rstn_next = '1;
                end

                default: begin
                    state_next = HOLD;
                    cnt_next   = '0;
                    stage_next = '0;
                    rstn_next  = '0;
                end
            endcase
        end

        busy_next = ~&rstn_next;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with default parameters (3 stages,
// 16-cycle pulse, 8-cycle gap). Frame edge 0 is the first edge after
// reset/request where the reset source is sampled low. In that frame the
// stages release at edges 24, 32 and 40, and done pulses on edge 40 only.
// Define RST_REQ_FILTER_EN for both files to exercise the request filter.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    logic       clock;
    logic       rstI;
    logic       reqI;
    logic [2:0] rstn;
    logic       busy;
    logic       done;
    logic [1:0] cause;

    int assertCount = 0;
    int failCount   = 0;

    reset_sequencer #(
        .NUM_STAGES    (3),
        .MIN_PULSE     (16),
        .STAGE_DLY     (8),
        .FILTER_CYCLES (4)
    ) dut (
        .clk_i       (clock),
        .rst_i       (rstI),
        .rst_req_i   (reqI),
        .rstn_o      (rstn),
        .busy_o      (busy),
        .done_o      (done),
        .rst_cause_o (cause)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive the inputs, then advance the given number of rising edges.
    // Control returns 1 time unit after the last edge, where outputs are stable.
    task automatic applyStimulus(input logic rst, input logic req, input int edges);
        rstI = rst;
        reqI = req;
        for (int i = 0; i < edges; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] expRstn,
                               input logic expBusy, input logic expDone,
                               input logic [1:0] expCause);
        assertCount++;
        assert (rstn === expRstn) else begin
            failCount++;
            $error("[TB] FAIL %s rstn_o observed %b expected %b", tag, rstn, expRstn);
        end
        assertCount++;
        assert (busy === expBusy) else begin
            failCount++;
            $error("[TB] FAIL %s busy_o observed %b expected %b", tag, busy, expBusy);
        end
        assertCount++;
        assert (done === expDone) else begin
            failCount++;
            $error("[TB] FAIL %s done_o observed %b expected %b", tag, done, expDone);
        end
        assertCount++;
        assert (cause === expCause) else begin
            failCount++;
            $error("[TB] FAIL %s rst_cause_o observed %b expected %b", tag, cause, expCause);
        end
    endtask

    // Expected release pattern at frame edge e for the default parameters.
    function automatic logic [2:0] expRstnAt(input int e);
        if (e >= 40)      return 3'b111;
        else if (e >= 32) return 3'b011;
        else if (e >= 24) return 3'b001;
        else              return 3'b000;
    endfunction

    // Run frame edges 0..lastEdge with both inputs low, checking every edge.
    task automatic runFrame(input int lastEdge, input logic [1:0] expCause, input string name);
        for (int e = 0; e <= lastEdge; e++) begin
            applyStimulus(1'b0, 1'b0, 1);
            checkOutput($sformatf("%s e%0d", name, e), expRstnAt(e), (e < 40), (e == 40), expCause);
        end
    endtask

    initial begin
        $display("[TB] reset_sequencer directed test start");

        // Power-on: rst_i high for 3 edges, then the full sequence.
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("resetState", 3'b000, 1'b1, 1'b0, 2'b00);
        runFrame(45, 2'b00, "powerOn");

`ifdef RST_REQ_FILTER_EN
        // A 3-cycle glitch is filtered out.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput($sformatf("glitch%0d", i), 3'b111, 1'b0, 1'b0, 2'b00);
        end
        applyStimulus(1'b0, 1'b0, 2);
        checkOutput("glitchAfter", 3'b111, 1'b0, 1'b0, 2'b00);

        // A 4-cycle request takes effect on its 4th edge.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput($sformatf("qualify%0d", i), 3'b111, 1'b0, 1'b0, 2'b00);
        end
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("qualified", 3'b000, 1'b1, 1'b0, 2'b01);
        runFrame(45, 2'b01, "filtSeq");
`else
        // A one-cycle request in RUN restarts the sequence.
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("reqPulse", 3'b000, 1'b1, 1'b0, 2'b01);
        runFrame(45, 2'b01, "reqSeq");

        // A request during RELEASE (after rstn=001) aborts that sequence.
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("abortEntry", 3'b000, 1'b1, 1'b0, 2'b01);
        runFrame(25, 2'b01, "abortPre");
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("abortHit", 3'b000, 1'b1, 1'b0, 2'b01);
        runFrame(45, 2'b01, "abortSeq");

        // rst_i and a request together: rst_i wins.
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("bothHigh", 3'b000, 1'b1, 1'b0, 2'b00);

        // A request held for 50 cycles keeps everything in reset.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 1'b1, 1);
            checkOutput($sformatf("reqHeld%0d", i), 3'b000, 1'b1, 1'b0, 2'b01);
        end
        runFrame(45, 2'b01, "afterHeld");

        // A request on the exact edge where the last stage would release.
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("finalEntry", 3'b000, 1'b1, 1'b0, 2'b01);
        runFrame(39, 2'b01, "preFinal");
        applyStimulus(1'b0, 1'b1, 1);
        checkOutput("finalCollide", 3'b000, 1'b1, 1'b0, 2'b01);
        runFrame(45, 2'b01, "recover");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
